// File: rtl/addsub_arb_ctrl_pkg.sv
// addsub_pkg: shared widths, default timings and FSM state encodings
package addsub_pkg;
   localparam int ADDSUB_W   = 4;
   localparam int DEF_SETTLE = 2;
   localparam int DEF_HOLD   = 8;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
endpackage

// File: rtl/addsub_arb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester that was not served last wins
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last,
   output logic gnt0,
   output logic gnt1,
   output logic gnt_id
);
   assign gnt0   = valid0 & (~valid1 | last);
   assign gnt1   = valid1 & (~valid0 | ~last);
   assign gnt_id = gnt1;
endmodule

// File: rtl/addsub_arb_ctrl.sv
// addsub_arb_ctrl: shares one add/sub display unit between two requesters,
// driving its operands, capturing its display after a settle time and holding it
module addsub_arb_ctrl
   import addsub_pkg::*;
#(
   parameter int W             = ADDSUB_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE,
   parameter int HOLD_CYCLES   = DEF_HOLD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_s,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_s,
   output logic         req1_ready,
   output logic [W-1:0] dp_a,
   output logic [W-1:0] dp_b,
   output logic         dp_s,
   input  logic [6:0]   dp_lcd,
   input  logic         dp_lcd_o,
   output logic [6:0]   lcd,
   output logic         lcd_o,
   output logic         busy,
   output logic         done,
   output logic         grant_id
);
   logic [1:0]   r_state;
   logic [7:0]   r_cnt;
   logic [W-1:0] r_dp_a, r_dp_b;
   logic         r_dp_s, r_lcd_o, r_done, r_grant, r_last;
   logic [6:0]   r_lcd;
   logic         w_gnt0, w_gnt1, w_gnt_id, w_idle, w_acc;

   rr_arb2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (r_last),
      .gnt0   (w_gnt0),
      .gnt1   (w_gnt1),
      .gnt_id (w_gnt_id)
   );

   // rst_n gates ready so nothing is offered while reset is asserted
   assign w_idle     = rst_n & (r_state == S_IDLE);
   assign req0_ready = w_idle & w_gnt0;
   assign req1_ready = w_idle & w_gnt1;
   assign w_acc      = req0_ready | req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dp_a  <= '0;
         r_dp_b  <= '0;
         r_dp_s  <= 1'b0;
         r_lcd   <= '0;
         r_lcd_o <= 1'b0;
         r_done  <= 1'b0;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (w_acc) begin
               r_dp_a  <= w_gnt_id ? req1_a : req0_a;
               r_dp_b  <= w_gnt_id ? req1_b : req0_b;
               r_dp_s  <= w_gnt_id ? req1_s : req0_s;
               r_grant <= w_gnt_id;
               r_last  <= w_gnt_id;
               r_cnt   <= 8'(SETTLE_CYCLES - 1);
               r_state <= S_DRIVE;
            end
            S_DRIVE: if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
            else begin
               r_lcd   <= dp_lcd;
               r_lcd_o <= dp_lcd_o;
               r_done  <= 1'b1;
               r_cnt   <= 8'(HOLD_CYCLES - 1);
               r_state <= S_HOLD;
            end
            S_HOLD: if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
            else r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dp_a     = r_dp_a;
   assign dp_b     = r_dp_b;
   assign dp_s     = r_dp_s;
   assign lcd      = r_lcd;
   assign lcd_o    = r_lcd_o;
   assign done     = r_done;
   assign grant_id = r_grant;
   assign busy     = r_state != S_IDLE;
endmodule

// File: tb/tb_addsub_arb_ctrl.sv
// tb_addsub_arb_ctrl: directed bench with a behavioural add/sub unit on dp_*
// (lcd = 5-bit a+b or a-b zero-extended, lcd_o = bit 4 of that result)
module tb_addsub_arb_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       req0_valid = 1'b0, req0_s = 1'b0, req1_valid = 1'b0, req1_s = 1'b0;
   logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       req0_ready, req1_ready, dp_s, dp_lcd_o, lcd_o, busy, done, grant_id;
   logic [3:0] dp_a, dp_b;
   logic [6:0] dp_lcd, lcd;
   logic [4:0] unit_r;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign unit_r   = dp_s ? {1'b0, dp_a} - {1'b0, dp_b} : {1'b0, dp_a} + {1'b0, dp_b};
   assign dp_lcd   = {2'b00, unit_r};
   assign dp_lcd_o = unit_r[4];

   addsub_arb_ctrl #(.W(4), .SETTLE_CYCLES(2), .HOLD_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s), .req1_ready(req1_ready),
      .dp_a(dp_a), .dp_b(dp_b), .dp_s(dp_s), .dp_lcd(dp_lcd), .dp_lcd_o(dp_lcd_o),
      .lcd(lcd), .lcd_o(lcd_o), .busy(busy), .done(done), .grant_id(grant_id)
   );

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if ({req0_ready, req1_ready, dp_a, dp_b, dp_s, lcd, lcd_o, busy, done, grant_id} !== 22'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0",
                     {req0_ready, req1_ready, dp_a, dp_b, dp_s, lcd, lcd_o, busy, done, grant_id});
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      {req0_a, req0_b, req0_s, req0_valid} = {4'd6, 4'd1, 1'b1, 1'b1};
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 1) req0_valid = 1'b0;
         #1;
         checks++;
         if ({busy, done} !== {1'(c <= 10), 1'(c == 3)}) begin
            errors++; $display("FAIL single_busy_done c=%0d: got %b expected %b", c, {busy, done}, {1'(c <= 10), 1'(c == 3)});
         end
         if (c == 1) begin
            checks++;
            if ({dp_a, dp_b, dp_s, grant_id} !== {4'd6, 4'd1, 1'b1, 1'b0}) begin
               errors++; $display("FAIL single_dp: got %h expected %h", {dp_a, dp_b, dp_s, grant_id}, {4'd6, 4'd1, 1'b1, 1'b0});
            end
         end
         if (c == 3) begin
            checks++;
            if ({lcd, lcd_o} !== {7'd5, 1'b0}) begin
               errors++; $display("FAIL single_lcd: got %h expected %h", {lcd, lcd_o}, {7'd5, 1'b0});
            end
         end
      end
   endtask

   task automatic test_contention();
      do_reset();
      {req0_a, req0_b, req0_s, req0_valid} = {4'd8, 4'd1, 1'b0, 1'b1};
      {req1_a, req1_b, req1_s, req1_valid} = {4'd2, 4'd1, 1'b0, 1'b1};
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL contention_first: got %b expected 10", {req0_ready, req1_ready});
      end
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1) req0_valid = 1'b0;
         if (c == 12) req1_valid = 1'b0;
         #1;
         checks++;
         if ({req1_ready, done} !== {1'(c == 11), 1'(c == 3 || c == 14)}) begin
            errors++; $display("FAIL contention_ready_done c=%0d: got %b expected %b", c, {req1_ready, done}, {1'(c == 11), 1'(c == 3 || c == 14)});
         end
         if (c == 1 || c == 12) begin
            checks++;
            if ({dp_a, grant_id} !== ((c == 1) ? {4'd8, 1'b0} : {4'd2, 1'b1})) begin
               errors++; $display("FAIL contention_grant c=%0d: got %h", c, {dp_a, grant_id});
            end
         end
         if (c == 3 || c == 14) begin
            checks++;
            if ({lcd, lcd_o} !== ((c == 3) ? {7'd9, 1'b0} : {7'd3, 1'b0})) begin
               errors++; $display("FAIL contention_lcd c=%0d: got %h", c, {lcd, lcd_o});
            end
         end
      end
   endtask

   task automatic test_fairness();
      int ops = 0, since = 99;
      logic [7:0] exp_lcd = '0;
      {req0_a, req0_b, req0_s, req0_valid} = {4'd15, 4'd1, 1'b0, 1'b1};
      {req1_a, req1_b, req1_s, req1_valid} = {4'd3, 4'd5, 1'b1, 1'b1};
      for (int c = 0; c < 80 && !(ops == 4 && since > 3); c++) begin
         if (c > 0) @(negedge clk);
         #1;
         since++;
         if (busy && (req0_ready || req1_ready)) begin
            checks++; errors++; $display("FAIL fairness_ready_while_busy c=%0d", c);
         end
         if (since == 3) begin
            checks++;
            if ({done, lcd, lcd_o} !== {1'b1, exp_lcd}) begin
               errors++; $display("FAIL fairness_capture op=%0d: got %h expected %h", ops, {done, lcd, lcd_o}, {1'b1, exp_lcd});
            end
         end
         if (ops < 4 && (req0_ready || req1_ready)) begin
            checks++;
            if ({req0_ready, req1_ready} !== ((ops % 2 == 0) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL fairness_order op=%0d: got %b", ops, {req0_ready, req1_ready});
            end
            exp_lcd = (ops % 2 == 0) ? {7'd16, 1'b1} : {7'd30, 1'b1};
            ops++;
            since = 0;
         end
      end
      checks++;
      if (ops != 4 || since <= 3) begin
         errors++; $display("FAIL fairness_timeout: got %0d ops expected 4", ops);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 20 && busy; c++) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_idle_wait: got busy=%b expected 0", busy);
      end
      {req1_a, req1_b, req1_s, req1_valid} = {4'd9, 4'd4, 1'b1, 1'b1};
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL reset_mid_ready: got %b expected 01", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++;
      if ({busy, dp_a} !== {1'b1, 4'd9}) begin
         errors++; $display("FAIL reset_mid_accept: got %h expected %h", {busy, dp_a}, {1'b1, 4'd9});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dp_a, dp_b, dp_s, lcd, lcd_o, busy, done, grant_id} !== 20'd0) begin
         errors++; $display("FAIL reset_mid_clear: got %h expected 0", {dp_a, dp_b, dp_s, lcd, lcd_o, busy, done, grant_id});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk); #1;
         checks++;
         if ({done, lcd} !== 8'd0) begin
            errors++; $display("FAIL reset_mid_no_done: got %h expected 0", {done, lcd});
         end
      end
      {req0_a, req0_b, req0_s, req0_valid} = {4'd9, 4'd3, 1'b0, 1'b1};
      {req1_a, req1_b, req1_s, req1_valid} = {4'd1, 4'd1, 1'b0, 1'b1};
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL reset_mid_tie: got %b expected 10", {req0_ready, req1_ready});
      end
   endtask

   task automatic test_hold();
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1) req0_valid = 1'b0;
         if (c == 12) req1_valid = 1'b0;
         #1;
         checks++;
         if (done !== 1'(c == 3 || c == 14)) begin
            errors++; $display("FAIL hold_done c=%0d: got %b expected %b", c, done, 1'(c == 3 || c == 14));
         end
         if (c >= 3) begin
            checks++;
            if ({lcd, lcd_o} !== ((c < 14) ? {7'd12, 1'b0} : {7'd2, 1'b0})) begin
               errors++; $display("FAIL hold_lcd c=%0d: got %h", c, {lcd, lcd_o});
            end
         end
         if (c == 12) begin
            checks++;
            if ({dp_a, dp_b, grant_id} !== {4'd1, 4'd1, 1'b1}) begin
               errors++; $display("FAIL hold_dp_change: got %h expected %h", {dp_a, dp_b, grant_id}, {4'd1, 4'd1, 1'b1});
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_reset_mid();
      test_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
